// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with a frame-aligned shadow register.
// Build option: define LEADING_ZERO_BLANK_EN to darken leading-zero digits (digit 0 always lit).
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    pending,
  output logic                    frame
);

  // state   | meaning
  // ST_WAIT | out of reset, anodes dark until the first refresh tick
  // ST_RUN  | scanning; a digit is lit whenever enable is high
  typedef enum logic {ST_WAIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DIV_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic [3:0]              r_digit;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_dp;
  logic                    r_frame;

  logic                    w_tick;
  logic                    w_boundary;
  logic                    w_commit;
  logic [DIV_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_disp_nxt;
  logic [NUM_DIGITS-1:0]   w_disp_dp_nxt;
  logic                    w_pending_nxt;
  logic                    w_blank;
  logic                    w_lit;
  logic [3:0]              w_digit_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic                    w_dp_nxt;

  // Prescaler, index and shadow/commit next-state
  always_comb begin
    w_tick     = enable && (r_cnt == CNT_LAST);
    w_boundary = w_tick && (r_idx == IDX_LAST);
    w_commit   = w_boundary && r_pending;

    w_cnt_nxt = r_cnt;
    if (enable) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + DIV_W'(1);
    end

    w_idx_nxt = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end

    w_disp_nxt    = w_commit ? r_shadow    : r_disp;
    w_disp_dp_nxt = w_commit ? r_shadow_dp : r_disp_dp;

    // A load on the boundary cycle re-arms pending after the old shadow is committed
    w_pending_nxt = r_pending;
    if (load) begin
      w_pending_nxt = 1'b1;
    end else if (w_boundary) begin
      w_pending_nxt = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_upper_zero;

  always_comb begin
    w_upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_upper_zero[i] = ((w_disp_nxt >> (4 * i)) == '0);
    end
    w_blank = (w_idx_nxt != '0) && w_upper_zero[w_idx_nxt] && !w_disp_dp_nxt[w_idx_nxt];
  end
`else
  always_comb begin
    w_blank = 1'b0;
  end
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT: if (w_tick) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  // FSM: outputs, computed from the next-state index and display value
  always_comb begin
    w_lit       = (w_state_nxt == ST_RUN) && enable && !w_blank;
    w_digit_nxt = w_disp_nxt[4*w_idx_nxt +: 4];
    w_an_nxt    = '1;
    w_dp_nxt    = 1'b1;
    if (w_lit) begin
      w_an_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
      w_dp_nxt = ~w_disp_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_pending   <= 1'b0;
      r_digit     <= 4'h0;
      r_an        <= '1;
      r_dp        <= 1'b1;
      r_frame     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_disp    <= w_disp_nxt;
      r_disp_dp <= w_disp_dp_nxt;
      r_pending <= w_pending_nxt;
      if (load) begin
        r_shadow    <= value;
        r_shadow_dp <= dp_in;
      end
      r_digit <= w_digit_nxt;
      r_an    <= w_an_nxt;
      r_dp    <= w_dp_nxt;
      r_frame <= w_boundary;
    end
  end

  assign digit   = r_digit;
  assign an      = r_an;
  assign dp      = r_dp;
  assign pending = r_pending;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=4.
// Blanking expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] value;
  logic          load;
  logic [ND-1:0] dp_in;
  logic          enable;
  logic [3:0]    digit;
  logic [ND-1:0] an;
  logic          dp;
  logic          pending;
  logic          frame;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
    .enable(enable), .digit(digit), .an(an), .dp(dp), .pending(pending), .frame(frame)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit is_blank(input int idx, input logic [15:0] d, input logic [3:0] dpv);
    bit b;
    b = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (d >> (4 * idx)) == 16'h0 && !dpv[idx]) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic logic [3:0] exp_an(input int idx, input logic [15:0] d, input logic [3:0] dpv);
    logic [3:0] one;
    one = 4'b0001;
    return is_blank(idx, d, dpv) ? 4'hF : ~(one << idx);
  endfunction

  function automatic logic exp_dp(input int idx, input logic [15:0] d, input logic [3:0] dpv);
    return is_blank(idx, d, dpv) ? 1'b1 : ~dpv[idx];
  endfunction

  task automatic wait_frame(input string tag);
    int k;
    k = 0;
    while (frame !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_frame_seen"}, {31'b0, frame}, 32'd1);
  endtask

  // Starts in the cycle right after a frame boundary; ends after the next one.
  task automatic check_frame(input string tag, input logic [15:0] d, input logic [3:0] dpv);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, "_digit"}, {28'b0, digit}, {28'b0, d[4*k +: 4]});
        chk({tag, "_an"}, {28'b0, an}, {28'b0, exp_an(k, d, dpv)});
        chk({tag, "_dp"}, {31'b0, dp}, {31'b0, exp_dp(k, d, dpv)});
        chk({tag, "_frame"}, {31'b0, frame}, {31'b0, (k == 0 && c == 0)});
        chk({tag, "_pending"}, {31'b0, pending}, 32'd0);
        step();
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    step(3);
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_dp", {31'b0, dp}, 32'd1);
    chk("rst_digit", {28'b0, digit}, 32'h0);
    chk("rst_pending", {31'b0, pending}, 32'd0);
    chk("rst_frame", {31'b0, frame}, 32'd0);

    // Release: dark until the first tick, then idx 1 of a zero display
    reset = 1'b0; enable = 1'b1;
    step(3);
    chk("pre_tick_an", {28'b0, an}, 32'hF);
    step();
    chk("first_tick_an", {28'b0, an}, {28'b0, exp_an(1, 16'h0, 4'h0)});
    chk("first_tick_digit", {28'b0, digit}, 32'h0);

    // Mid-frame load, shown from the next frame
    step();
    load = 1'b1; value = 16'h1A3F; dp_in = 4'b0100;
    step();
    load = 1'b0;
    chk("load_pending", {31'b0, pending}, 32'd1);
    chk("load_not_shown", {28'b0, digit}, 32'h0);
    wait_frame("f1");
    check_frame("f1", 16'h1A3F, 4'b0100);

    // Two loads in one frame: only the last is displayed
    step(2);
    load = 1'b1; value = 16'h1111; dp_in = 4'b0000;
    step();
    load = 1'b0;
    chk("dbl_pending", {31'b0, pending}, 32'd1);
    step(2);
    load = 1'b1; value = 16'h2222;
    step();
    load = 1'b0;
    wait_frame("f2");
    check_frame("f2", 16'h2222, 4'b0000);

    // Disable mid-digit for 10 cycles; load while disabled is accepted
    step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("dis_an", {28'b0, an}, 32'hF);
      chk("dis_dp", {31'b0, dp}, 32'd1);
      if (i == 4) begin
        load = 1'b1; value = 16'h0050;
      end
      if (i == 5) begin
        load = 1'b0;
        chk("dis_load_pending", {31'b0, pending}, 32'd1);
      end
    end
    enable = 1'b1;
    step();
    chk("resume_an0", {28'b0, an}, 32'hE);
    chk("resume_digit", {28'b0, digit}, 32'h2);
    step();
    chk("resume_an1", {28'b0, an}, 32'hE);
    step();
    chk("resume_cnt_kept", {28'b0, an}, 32'hD);
    wait_frame("f3");
    check_frame("f3", 16'h0050, 4'b0000);

    // Reset while pending: shadow discarded
    step(3);
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    chk("rst2_pending_before", {31'b0, pending}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_an", {28'b0, an}, 32'hF);
    chk("rst2_dp", {31'b0, dp}, 32'd1);
    chk("rst2_digit", {28'b0, digit}, 32'h0);
    chk("rst2_pending", {31'b0, pending}, 32'd0);
    chk("rst2_frame", {31'b0, frame}, 32'd0);
    step(3);
    chk("rst2_pre_tick_an", {28'b0, an}, 32'hF);
    step();
    chk("rst2_first_tick_an", {28'b0, an}, {28'b0, exp_an(1, 16'h0, 4'h0)});
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst2_shadow_dropped", {28'b0, digit}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
